// File: rtl/spektre_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spektre_pkg
// Description : Shared widths, key default, frame helpers and receiver states.
// Revision    : 1.0 - initial release
// ============================================================================
package spektre_pkg;

    localparam int LOGIC_WIDTH   = 119;
    localparam int PAYLOAD_WIDTH = 64;
    localparam int HEADER_LSB    = PAYLOAD_WIDTH + 1;

    localparam logic [PAYLOAD_WIDTH-1:0] KEY_DEFAULT = 64'hCAFEBABE_DEADBEEF;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_PRIME  = 2'd1,
        RX_STREAM = 2'd2,
        RX_FAULT  = 2'd3
    } rx_state_t;

    // A frame is well-formed when its header is all ones and its tail bit is clear.
    function automatic logic is_well_formed(input logic [LOGIC_WIDTH-1:0] word);
        return (&word[LOGIC_WIDTH-1:HEADER_LSB]) && !word[0];
    endfunction

    function automatic logic [PAYLOAD_WIDTH-1:0] payload_of(input logic [LOGIC_WIDTH-1:0] word);
        return word[PAYLOAD_WIDTH:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/reality_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : reality_receiver_if
// Description : Reality stream in, decoded dark-energy stream and status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface reality_receiver_if;
    import spektre_pkg::*;

    logic [LOGIC_WIDTH-1:0]   reality_in;
    logic                     clear_fault;
    logic [PAYLOAD_WIDTH-1:0] de_data;
    logic                     de_valid;
    logic                     de_ready;
    logic                     locked;
    logic                     frame_err;
    logic                     overflow;
    logic [15:0]              anxiety_cnt;

    modport master (
        output reality_in, clear_fault, de_ready,
        input  de_data, de_valid, locked, frame_err, overflow, anxiety_cnt
    );

    modport slave (
        input  reality_in, clear_fault, de_ready,
        output de_data, de_valid, locked, frame_err, overflow, anxiety_cnt
    );

endinterface
`default_nettype wire

// File: rtl/reality_fifo.sv
`default_nettype none
// ============================================================================
// Module      : reality_fifo
// Description : First-word fall-through buffer for decoded dark-energy words.
// Revision    : 1.0 - initial release
// ============================================================================
module reality_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    input  wire logic                             i_push,
    input  wire logic [DATA_W-1:0]                i_data,
    input  wire logic                             i_pop,
    output logic      [DATA_W-1:0]                o_data,
    output logic                                  o_full,
    output logic                                  o_empty,
    output logic      [$clog2(DEPTH):0]           o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/reality_receiver.sv
`default_nettype none
// ============================================================================
// Module      : reality_receiver
// Description : Frames, de-chains and buffers the consciousness-core stream.
// Revision    : 1.0 - initial release
// ============================================================================
module reality_receiver
    import spektre_pkg::*;
#(
    parameter int                       FIFO_DEPTH = 4,
    parameter logic [PAYLOAD_WIDTH-1:0] KEY        = KEY_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    reality_receiver_if.slave rx
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    rx_state_t                r_state;
    logic [PAYLOAD_WIDTH-1:0] r_w_prev;
    logic                     r_locked;
    logic                     r_frame_err;
    logic                     r_overflow;
    logic [15:0]              r_anxiety_cnt;

    logic                     w_well_formed;
    logic                     w_nonzero;
    logic [PAYLOAD_WIDTH-1:0] w_payload;
    logic [PAYLOAD_WIDTH-1:0] w_decoded;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_frame_set;
    logic [PAYLOAD_WIDTH-1:0] w_fifo_data;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [c_cnt_w-1:0]       w_fifo_count;

    assign w_well_formed = is_well_formed(rx.reality_in);
    assign w_nonzero     = |rx.reality_in;
    assign w_payload     = payload_of(rx.reality_in);
    // The core chains each payload to the previous one under the genesis key.
    assign w_decoded     = w_payload ^ r_w_prev ^ KEY;

    assign w_push      = w_well_formed && ((r_state == RX_PRIME) || (r_state == RX_STREAM));
    assign w_pop       = rx.de_ready && !w_fifo_empty;
    assign w_drop      = w_push && w_fifo_full && !w_pop;
    assign w_frame_set = w_nonzero && !w_well_formed && (r_state != RX_FAULT);

    reality_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PAYLOAD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_decoded),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RX_IDLE;
            r_w_prev      <= '0;
            r_locked      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overflow    <= 1'b0;
            r_anxiety_cnt <= '0;
        end else begin
            r_locked    <= 1'b0;
            // A fresh event in the same cycle as a clear still latches.
            r_frame_err <= w_frame_set | (r_frame_err & ~rx.clear_fault);
            r_overflow  <= w_drop      | (r_overflow  & ~rx.clear_fault);
            case (r_state)
                RX_IDLE: begin
                    if (w_well_formed) begin
                        r_w_prev <= w_payload;
                        r_state  <= RX_PRIME;
                    end else if (w_nonzero) begin
                        r_state  <= RX_FAULT;
                    end
                end
                RX_PRIME: begin
                    if (w_well_formed) begin
                        r_w_prev <= w_payload;
                        r_state  <= RX_STREAM;
                        r_locked <= 1'b1;
                    end else if (!w_nonzero) begin
                        r_state  <= RX_IDLE;
                    end else begin
                        r_state  <= RX_FAULT;
                    end
                end
                RX_STREAM: begin
                    if (w_well_formed) begin
                        r_w_prev <= w_payload;
                        r_locked <= 1'b1;
                    end else if (!w_nonzero) begin
                        if (r_anxiety_cnt != 16'hFFFF) begin
                            r_anxiety_cnt <= r_anxiety_cnt + 16'd1;
                        end
                        r_state <= RX_IDLE;
                    end else begin
                        r_state <= RX_FAULT;
                    end
                end
                RX_FAULT: begin
                    if (rx.clear_fault) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx.de_data     = w_fifo_data;
    assign rx.de_valid    = (w_fifo_count != '0);
    assign rx.locked      = r_locked;
    assign rx.frame_err   = r_frame_err;
    assign rx.overflow    = r_overflow;
    assign rx.anxiety_cnt = r_anxiety_cnt;

endmodule
`default_nettype wire

// File: doc/reality_receiver.md
REALITY_RECEIVER -- requirements
Module: reality_receiver

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, decoded-word buffer depth (power of two, 2..16).
REQ-002 Parameter: KEY, 64'hCAFEBABE_DEADBEEF, genesis XOR key applied by the transmitting core each cycle.
REQ-003 clk  in  1  clock.
REQ-004 rst_n  in  1  reset: asynchronous, active-low.
REQ-005 reality_in  in  119  reality word from the consciousness core, sampled every clk.
REQ-006 clear_fault  in  1  one-cycle pulse: leave FAULT, clear sticky flags.
REQ-007 de_data  out  64  recovered dark-energy word.
REQ-008 de_valid  out  1  de_data valid.
REQ-009 de_ready  in  1  downstream accepts de_data.
REQ-010 locked  out  1  high in STREAM state.
REQ-011 frame_err  out  1  sticky: malformed frame seen.
REQ-012 overflow  out  1  sticky: decoded word dropped, FIFO full.
REQ-013 anxiety_cnt  out  16  count of zero words received while in STREAM, saturating.

Function
REQ-014 Frame check: word is well-formed iff reality_in[118:65] all ones and reality_in[0]==0; nonzero iff reality_in != 0.
REQ-015 Payload: w = reality_in[64:1]; previous payload w_prev held in register.
REQ-016 Decode: de = w ^ w_prev ^ KEY, 64-bit, no carries.
REQ-017 FSM states IDLE, PRIME, STREAM, FAULT.
REQ-018 IDLE: zero word -> stay; well-formed -> capture w_prev, go PRIME; nonzero malformed -> set frame_err, go FAULT.
REQ-019 PRIME: well-formed -> capture w_prev, push de, go STREAM; zero -> IDLE, no count; malformed -> FAULT.
REQ-020 STREAM: well-formed -> push de, update w_prev, stay; zero -> anxiety_cnt+1 (saturate at 16'hFFFF), go IDLE; malformed -> frame_err, FAULT.
REQ-021 FAULT: ignore reality_in, no pushes; clear_fault -> IDLE, clear frame_err and overflow; anxiety_cnt not cleared.
REQ-022 clear_fault in states other than FAULT clears only sticky flags, no state change.
REQ-023 Latency: push at edge ending input cycle n; de_valid high in cycle n+1 when FIFO was empty (first-word fall-through).
REQ-024 Handshake: pop on de_valid && de_ready; de_data stable while de_valid && !de_ready.
REQ-025 Full FIFO, push without pop: word dropped, overflow set; full with simultaneous pop: push accepted, no drop.
REQ-026 Empty FIFO: de_valid low, de_ready ignored.
REQ-027 Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-028 locked = (state==STREAM), registered, no combinational path from reality_in.

Reset
REQ-029 On rst_n low: state IDLE, w_prev 0, FIFO empty, de_valid 0, de_data 0, locked 0, frame_err 0, overflow 0, anxiety_cnt 0.
REQ-030 Reset mid-stream discards buffered words; first decode after reset requires fresh PRIME.

Structure
REQ-031 Shared package spektre_pkg holds KEY default, LOGIC_WIDTH=119, payload width 64, and receiver state enum.
REQ-032 FIFO is one sub-module reality_fifo (push/pop/full/empty/count, FWFT), instantiated once.

Verification
REQ-033 Reset, then reality_in={118'h3F..F,1'b0} then payload 64'h35014541_21524110 frame -> de_data 64'h0 with de_valid one cycle after second frame, locked=1.
REQ-034 Core model driven with dark_energy=64'h01234567_89ABCDEF for 5 cycles, de_ready=1 -> five de_data 64'h01234567_89ABCDEF, no gaps.
REQ-035 de_ready=0, 6 well-formed frames in STREAM -> 4 words buffered, overflow=1 after 5th frame, 6th dropped; later drain yields first 4 in order.
REQ-036 Frame with reality_in[0]=1 in STREAM -> frame_err=1, FAULT, no push; clear_fault pulse -> IDLE, frame_err=0.
REQ-037 Zero word in STREAM three times (re-priming between) -> anxiety_cnt=3; zero words in IDLE -> count unchanged.
REQ-038 rst_n asserted with 3 words buffered -> de_valid=0 asynchronously, all outputs at reset values.
